// File: rtl/ble_cmd_assembler_if.sv
// Bundle between the BLE UART transceiver / cmd_proc and ble_cmd_assembler.
// The slave modport is the assembler's view; master is the surrounding logic.
interface ble_cmd_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        timeout_err;

  // Handshakes: a byte moves when the assembler accepts rx_rdy and answers
  // with a one-cycle clr_rx_rdy. A command is offered by holding cmd_rdy and
  // cmd until clr_cmd_rdy. A transmit starts on a one-cycle trmt and is
  // complete on a one-cycle tx_done.
  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, timeout_err
  );

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, timeout_err
  );
endinterface

// File: rtl/ble_cmd_assembler.sv
// Assembles two UART bytes (high first) into a 16-bit command and turns send_resp
// into a single acknowledge transmit. Optional inter-byte timeout: BYTE_TIMEOUT_EN.
module ble_cmd_assembler #(
  parameter logic [7:0] RESP_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  ble_cmd_assembler_if.slave   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cmd_q, cmd_nxt;
  logic        cmd_rdy_q, cmd_rdy_nxt;
  logic        terr_q, terr_nxt;
  logic        acc_d1, acc_d2;
  logic        accept;
  logic        timeout_hit;
  logic        trmt_q, tx_busy, resp_pend;
  logic        issue;

  // The receiver needs two cycles to drop rx_rdy after a consume, so a byte
  // accepted in either of the two previous cycles must not be taken again.
  assign accept = bus.rx_rdy && (state == IDLE || state == HIGH) && !acc_d1 && !acc_d2;

`ifdef BYTE_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign timeout_hit = (state == HIGH) && (tmo_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE && accept) begin
      tmo_cnt <= '0;
    end else if (state == HIGH && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      terr_q    <= 1'b0;
      acc_d1    <= 1'b0;
      acc_d2    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_q     <= cmd_nxt;
      cmd_rdy_q <= cmd_rdy_nxt;
      terr_q    <= terr_nxt;
      acc_d1    <= accept;
      acc_d2    <= acc_d1;
    end
  end

  // A low-byte accept overrides a coincident clr_cmd_rdy, so the new command
  // is always visible for at least one cycle.
  always_comb begin
    state_nxt   = state;
    cmd_nxt     = cmd_q;
    cmd_rdy_nxt = cmd_rdy_q;
    terr_nxt    = 1'b0;
    if (bus.clr_cmd_rdy) cmd_rdy_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cmd_nxt[15:8] = bus.rx_data;
          state_nxt     = HIGH;
        end
      end
      HIGH: begin
        if (accept) begin
          cmd_nxt[7:0] = bus.rx_data;
          cmd_rdy_nxt  = 1'b1;
          state_nxt    = FULL;
        end else if (timeout_hit) begin
          terr_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      FULL: begin
        if (bus.clr_cmd_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One acknowledge may wait behind a transmit in flight; extras are dropped.
  assign issue = (bus.send_resp || resp_pend) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      trmt_q    <= 1'b0;
      tx_busy   <= 1'b0;
      resp_pend <= 1'b0;
    end else begin
      trmt_q <= issue;
      if (issue) begin
        tx_busy   <= 1'b1;
        resp_pend <= 1'b0;
      end else begin
        if (bus.tx_done) tx_busy <= 1'b0;
        if (bus.send_resp && tx_busy) resp_pend <= 1'b1;
      end
    end
  end

  assign bus.clr_rx_rdy  = acc_d1;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.trmt        = trmt_q;
  assign bus.tx_data     = RESP_BYTE;
  assign bus.timeout_err = terr_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_ble_cmd_assembler.sv
// Directed bench for ble_cmd_assembler: table of byte pairs plus hand sequences
// for back-pressure, timeout, response pending, mid-command reset and held clear.
module tb_ble_cmd_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ble_cmd_assembler_if bus();

  ble_cmd_assembler dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_cmd;
  } vec_t;

  vec_t vecs[4];

  int checks   = 0;
  int errors   = 0;
  int clr_cnt  = 0;
  int trmt_cnt = 0;
  int terr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and tally output pulses seen there.
  task automatic step();
    @(negedge clk);
    if (bus.clr_rx_rdy)  clr_cnt++;
    if (bus.trmt)        trmt_cnt++;
    if (bus.timeout_err) terr_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_low, input logic [15:0] exp_cmd);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    while (!seen && n < 200) begin
      step();
      n++;
      if (bus.clr_rx_rdy) seen = 1'b1;
    end
    chk("rx_accept", 32'(seen), 32'd1);
    if (seen) begin
      if (is_low) begin
        chk("cmd_rdy_set", 32'(bus.cmd_rdy), 32'd1);
        chk("cmd_value", 32'(bus.cmd), 32'(exp_cmd));
      end else begin
        chk("cmd_rdy_after_hi", 32'(bus.cmd_rdy), 32'd0);
      end
      step();
      chk("clr_rx_pulse_len", 32'(bus.clr_rx_rdy), 32'd0);
    end
    bus.rx_rdy = 1'b0;
  endtask

  task automatic consume(input logic [15:0] exp_cmd);
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_cleared", 32'(bus.cmd_rdy), 32'd0);
    chk("cmd_kept", 32'(bus.cmd), 32'(exp_cmd));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int base;
    int n;
    bit seen;

    vecs[0] = '{hi: 8'h23, lo: 8'h45, exp_cmd: 16'h2345};
    vecs[1] = '{hi: 8'hFF, lo: 8'h00, exp_cmd: 16'hFF00};
    vecs[2] = '{hi: 8'h00, lo: 8'hFF, exp_cmd: 16'h00FF};
    vecs[3] = '{hi: 8'hA5, lo: 8'h5A, exp_cmd: 16'hA55A};

    rst             = 1'b1;
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.tx_done     = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_cmd", 32'(bus.cmd), 32'h0);
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("rst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);
    chk("rst_trmt", 32'(bus.trmt), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("tx_data_const", 32'(bus.tx_data), 32'hA5);

    // Table-driven command assembly
    for (int i = 0; i < 4; i++) begin
      base = clr_cnt;
      send_byte(vecs[i].hi, 1'b0, 16'h0);
      send_byte(vecs[i].lo, 1'b1, vecs[i].exp_cmd);
      chk("cmd_rdy_held", 32'(bus.cmd_rdy), 32'd1);
      step();
      chk("cmd_rdy_held2", 32'(bus.cmd_rdy), 32'd1);
      chk("clr_rx_pulses", 32'(clr_cnt - base), 32'd2);
      consume(vecs[i].exp_cmd);
    end

    // Back-pressure while a command is unconsumed
    send_byte(8'h12, 1'b0, 16'h0);
    send_byte(8'h34, 1'b1, 16'h1234);
    base = clr_cnt;
    bus.rx_data = 8'h40;
    bus.rx_rdy  = 1'b1;
    repeat (10) step();
    chk("full_no_clr_rx", 32'(clr_cnt - base), 32'd0);
    chk("full_state", 32'(dbg_state), 32'd2);
    chk("full_cmd_stable", 32'(bus.cmd), 32'h1234);
    consume(16'h1234);
    send_byte(8'h40, 1'b0, 16'h0);
    send_byte(8'h41, 1'b1, 16'h4041);
    consume(16'h4041);

    // Inter-byte timeout (or its absence)
    send_byte(8'h12, 1'b0, 16'h0);
`ifdef BYTE_TIMEOUT_EN
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60000) begin
      step();
      n++;
      if (bus.timeout_err) seen = 1'b1;
    end
    chk("timeout_seen", 32'(seen), 32'd1);
    chk("timeout_latency", 32'(n), 32'd49999);
    chk("timeout_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("timeout_cmd_hi", 32'(bus.cmd[15:8]), 32'h12);
    step();
    chk("timeout_pulse_len", 32'(bus.timeout_err), 32'd0);
    chk("timeout_idle", 32'(dbg_state), 32'd0);
    send_byte(8'h00, 1'b0, 16'h0);
    send_byte(8'h01, 1'b1, 16'h0001);
    consume(16'h0001);
`else
    n    = 0;
    seen = 1'b0;
    repeat (200) step();
    chk("no_timeout_err", 32'(terr_cnt), 32'd0);
    chk("high_waits", 32'(dbg_state), 32'd1);
    send_byte(8'h9C, 1'b1, 16'h129C);
    consume(16'h129C);
`endif

    // Response path: immediate, pended, dropped duplicate, coincident with tx_done
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    chk("trmt_first", 32'(bus.trmt), 32'd1);
    chk("trmt_tx_data", 32'(bus.tx_data), 32'hA5);
    step();
    chk("trmt_pulse_len", 32'(bus.trmt), 32'd0);
    base = trmt_cnt;
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    step();
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    repeat (3) step();
    chk("busy_no_trmt", 32'(trmt_cnt - base), 32'd0);
    base = trmt_cnt;
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("pend_trmt_not_yet", 32'(bus.trmt), 32'd0);
    step();
    chk("pend_trmt", 32'(bus.trmt), 32'd1);
    repeat (5) step();
    chk("pend_depth_one", 32'(trmt_cnt - base), 32'd1);
    base = trmt_cnt;
    bus.send_resp = 1'b1;
    bus.tx_done   = 1'b1;
    step();
    bus.send_resp = 1'b0;
    bus.tx_done   = 1'b0;
    chk("coinc_trmt_not_yet", 32'(bus.trmt), 32'd0);
    step();
    chk("coinc_trmt", 32'(bus.trmt), 32'd1);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    repeat (4) step();
    chk("coinc_single", 32'(trmt_cnt - base), 32'd1);

    // Reset in the middle of a command and a transmit
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    send_byte(8'h34, 1'b0, 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cmd", 32'(bus.cmd), 32'h0);
    chk("mid_rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("mid_rst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);
    chk("mid_rst_trmt", 32'(bus.trmt), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
    chk("rst_clears_busy", 32'(bus.trmt), 32'd1);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    send_byte(8'h56, 1'b0, 16'h0);
    send_byte(8'h78, 1'b1, 16'h5678);
    consume(16'h5678);

    // clr_cmd_rdy held across the low-byte accept
    bus.clr_cmd_rdy = 1'b1;
    send_byte(8'h9A, 1'b0, 16'h0);
    send_byte(8'hBC, 1'b1, 16'h9ABC);
    chk("held_clr_one_cycle", 32'(bus.cmd_rdy), 32'd0);
    chk("held_clr_idle", 32'(dbg_state), 32'd0);
    bus.clr_cmd_rdy = 1'b0;
    step();
    chk("held_clr_stays_low", 32'(bus.cmd_rdy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
